// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: lock acquisition and supervision sequencer for a digital PLL.
// Walks the loop through preset, wide-gain and narrow-gain acquisition into
// qualified lock, watches for lock loss and reference loss, and counts retries.
// All outputs are registered and reflect the state held in the same cycle.

module pll_lock_ctrl #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int HOLD_CYC   = 8,
  parameter int ACQ_EDGES  = 1024,
  parameter int EDGE_TO    = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ref_edge,
  input  logic       lock_in,
  output logic       pll_hold,
  output logic [1:0] gain_sel,
  output logic       lock_good,
  output logic       lost_lock,
  output logic       no_ref,
  output logic [2:0] state,
  output logic [7:0] retry_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESET     = 3'd1,
    ST_ACQ_WIDE   = 3'd2,
    ST_ACQ_NARROW = 3'd3,
    ST_LOCKED     = 3'd4,
    ST_NOREF      = 3'd5
  } state_t;

  // Terminal counter values: a counter sitting at *_LAST means the current
  // event is the one that completes the threshold.
  localparam logic [7:0]  HOLD_LAST   = 8'(HOLD_CYC - 1);
  localparam logic [7:0]  LOCK_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [7:0]  UNLOCK_LAST = 8'(UNLOCK_CNT - 1);
  localparam logic [7:0]  LOCK_MAX    = 8'(LOCK_CNT);
  localparam logic [7:0]  UNLOCK_MAX  = 8'(UNLOCK_CNT);
  localparam logic [15:0] BUDGET_LAST = 16'(ACQ_EDGES - 1);
  localparam logic [15:0] BUDGET_MAX  = 16'(ACQ_EDGES);
  localparam logic [15:0] TMR_LAST    = 16'(EDGE_TO - 1);
  localparam logic [7:0]  RETRY_MAX   = 8'd255;

  state_t      state_r;
  state_t      nxt_state_s;
  logic [7:0]  hold_cnt_r;
  logic [7:0]  good_cnt_r;
  logic [7:0]  bad_cnt_r;
  logic [15:0] budget_cnt_r;
  logic [15:0] edge_tmr_r;

  logic        good_edge_s;
  logic        bad_edge_s;
  logic        good_last_s;
  logic        bad_last_s;
  logic        budget_last_s;
  logic        hold_done_s;
  logic        timeout_s;

  // PLL hold is asserted whenever the loop must not track the reference.
  function automatic logic hold_of(input state_t s);
    logic h;
    case (s)
      ST_IDLE, ST_PRESET, ST_NOREF: h = 1'b1;
      default:                      h = 1'b0;
    endcase
    return h;
  endfunction

  // Loop gain schedule: wide until narrow acquisition, narrowest once locked.
  function automatic logic [1:0] gain_of(input state_t s);
    logic [1:0] g;
    case (s)
      ST_ACQ_NARROW: g = 2'd1;
      ST_LOCKED:     g = 2'd0;
      default:       g = 2'd2;
    endcase
    return g;
  endfunction

  assign state = state_r;

  // Classify the current reference event and detect threshold crossings.
  always_comb begin
    good_edge_s   = ref_edge & lock_in;
    bad_edge_s    = ref_edge & ~lock_in;
    good_last_s   = good_edge_s & (good_cnt_r == LOCK_LAST);
    bad_last_s    = bad_edge_s & (bad_cnt_r == UNLOCK_LAST);
    budget_last_s = ref_edge & (budget_cnt_r == BUDGET_LAST);
    hold_done_s   = (hold_cnt_r == HOLD_LAST);
    // A reference edge in the would-be timeout cycle always rescues the timer.
    timeout_s     = ~ref_edge & (edge_tmr_r == TMR_LAST);
  end

  // Next-state decision; enable low overrides every acquisition rule.
  always_comb begin
    nxt_state_s = state_r;
    if (!enable) begin
      nxt_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          nxt_state_s = ST_PRESET;
        end
        ST_PRESET: begin
          if (hold_done_s) begin
            nxt_state_s = ST_ACQ_WIDE;
          end else begin
            nxt_state_s = ST_PRESET;
          end
        end
        ST_ACQ_WIDE: begin
          if (timeout_s) begin
            nxt_state_s = ST_NOREF;
          end else if (good_last_s) begin
            nxt_state_s = ST_ACQ_NARROW;
          end else if (budget_last_s) begin
            nxt_state_s = ST_PRESET;
          end else begin
            nxt_state_s = ST_ACQ_WIDE;
          end
        end
        ST_ACQ_NARROW: begin
          if (timeout_s) begin
            nxt_state_s = ST_NOREF;
          end else if (bad_edge_s) begin
            nxt_state_s = ST_ACQ_WIDE;
          end else if (good_last_s) begin
            nxt_state_s = ST_LOCKED;
          end else begin
            nxt_state_s = ST_ACQ_NARROW;
          end
        end
        ST_LOCKED: begin
          if (timeout_s) begin
            nxt_state_s = ST_NOREF;
          end else if (bad_last_s) begin
            nxt_state_s = ST_ACQ_WIDE;
          end else begin
            nxt_state_s = ST_LOCKED;
          end
        end
        ST_NOREF: begin
          if (ref_edge) begin
            nxt_state_s = ST_PRESET;
          end else begin
            nxt_state_s = ST_NOREF;
          end
        end
        default: begin
          nxt_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register, registered Moore outputs, retry counter and per-state counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pll_hold     <= 1'b1;
      gain_sel     <= 2'd2;
      lock_good    <= 1'b0;
      lost_lock    <= 1'b0;
      no_ref       <= 1'b0;
      retry_cnt    <= 8'd0;
      hold_cnt_r   <= 8'd0;
      good_cnt_r   <= 8'd0;
      bad_cnt_r    <= 8'd0;
      budget_cnt_r <= 16'd0;
      edge_tmr_r   <= 16'd0;
    end else begin
      state_r   <= nxt_state_s;
      pll_hold  <= hold_of(nxt_state_s);
      gain_sel  <= gain_of(nxt_state_s);
      lock_good <= (nxt_state_s == ST_LOCKED);
      no_ref    <= (nxt_state_s == ST_NOREF);
      // Loss of lock is flagged only when leaving LOCKED for a fault, not on disable.
      lost_lock <= (state_r == ST_LOCKED) &&
                   ((nxt_state_s == ST_ACQ_WIDE) || (nxt_state_s == ST_NOREF));

      if (nxt_state_s == ST_IDLE) begin
        retry_cnt <= 8'd0;
      end else if ((state_r == ST_ACQ_WIDE) && (nxt_state_s == ST_PRESET) &&
                   (retry_cnt != RETRY_MAX)) begin
        retry_cnt <= retry_cnt + 8'd1;
      end else begin
        retry_cnt <= retry_cnt;
      end

      if (nxt_state_s != state_r) begin
        // Every state entry starts with all run/budget/timer counters at zero.
        hold_cnt_r   <= 8'd0;
        good_cnt_r   <= 8'd0;
        bad_cnt_r    <= 8'd0;
        budget_cnt_r <= 16'd0;
        edge_tmr_r   <= 16'd0;
      end else begin
        case (state_r)
          ST_PRESET: begin
            if (hold_cnt_r != HOLD_LAST) begin
              hold_cnt_r <= hold_cnt_r + 8'd1;
            end
          end
          ST_ACQ_WIDE: begin
            if (ref_edge) begin
              edge_tmr_r <= 16'd0;
              if (budget_cnt_r != BUDGET_MAX) begin
                budget_cnt_r <= budget_cnt_r + 16'd1;
              end
              if (!lock_in) begin
                good_cnt_r <= 8'd0;
              end else if (good_cnt_r != LOCK_MAX) begin
                good_cnt_r <= good_cnt_r + 8'd1;
              end
            end else begin
              edge_tmr_r <= edge_tmr_r + 16'd1;
            end
          end
          ST_ACQ_NARROW: begin
            if (ref_edge) begin
              edge_tmr_r <= 16'd0;
              if (lock_in && (good_cnt_r != LOCK_MAX)) begin
                good_cnt_r <= good_cnt_r + 8'd1;
              end
            end else begin
              edge_tmr_r <= edge_tmr_r + 16'd1;
            end
          end
          ST_LOCKED: begin
            if (ref_edge) begin
              edge_tmr_r <= 16'd0;
              if (lock_in) begin
                bad_cnt_r <= 8'd0;
              end else if (bad_cnt_r != UNLOCK_MAX) begin
                bad_cnt_r <= bad_cnt_r + 8'd1;
              end
            end else begin
              edge_tmr_r <= edge_tmr_r + 16'd1;
            end
          end
          default: begin
            hold_cnt_r   <= hold_cnt_r;
            good_cnt_r   <= good_cnt_r;
            bad_cnt_r    <= bad_cnt_r;
            budget_cnt_r <= budget_cnt_r;
            edge_tmr_r   <= edge_tmr_r;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl: directed scenarios plus a random soak,
// every cycle compared against a run-length based behavioural model.

module tb_pll_lock_ctrl;

  localparam int LOCK_CNT   = 5;
  localparam int UNLOCK_CNT = 4;
  localparam int HOLD_CYC   = 8;
  localparam int ACQ_EDGES  = 24;
  localparam int EDGE_TO    = 50;

  localparam int S_IDLE = 0, S_PRESET = 1, S_WIDE = 2, S_NARROW = 3, S_LOCKED = 4, S_NOREF = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       ref_edge = 1'b0;
  logic       lock_in = 1'b0;
  logic       pll_hold;
  logic [1:0] gain_sel;
  logic       lock_good;
  logic       lost_lock;
  logic       no_ref;
  logic [2:0] state;
  logic [7:0] retry_cnt;

  pll_lock_ctrl #(
    .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .HOLD_CYC(HOLD_CYC),
    .ACQ_EDGES(ACQ_EDGES), .EDGE_TO(EDGE_TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ref_edge(ref_edge), .lock_in(lock_in),
    .pll_hold(pll_hold), .gain_sel(gain_sel), .lock_good(lock_good),
    .lost_lock(lost_lock), .no_ref(no_ref), .state(state), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: state, cycles spent, polarity runs, edges seen, quiet time.
  int m_state = 0;
  int m_dwell = 0;
  int m_run_good = 0;
  int m_run_bad = 0;
  int m_edges = 0;
  int m_quiet = 0;
  int m_retry = 0;
  int m_lost = 0;
  int m_fail_events = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int ns;
    if (rst) begin
      m_state = S_IDLE; m_dwell = 0; m_run_good = 0; m_run_bad = 0;
      m_edges = 0; m_quiet = 0; m_retry = 0; m_lost = 0;
    end else begin
      ns = m_state;
      if (!enable) begin
        ns = S_IDLE;
      end else if (m_state == S_IDLE) begin
        ns = S_PRESET;
      end else if (m_state == S_PRESET) begin
        m_dwell++;
        if (m_dwell >= HOLD_CYC) ns = S_WIDE;
      end else if (m_state == S_WIDE || m_state == S_NARROW || m_state == S_LOCKED) begin
        if (ref_edge) begin
          m_quiet = 0;
          m_edges++;
          if (lock_in) begin m_run_good++; m_run_bad = 0; end
          else begin m_run_bad++; m_run_good = 0; end
        end else begin
          m_quiet++;
        end
        if (!ref_edge && m_quiet >= EDGE_TO) ns = S_NOREF;
        else if (m_state == S_WIDE) begin
          if (m_run_good >= LOCK_CNT) ns = S_NARROW;
          else if (m_edges >= ACQ_EDGES) begin
            ns = S_PRESET;
            m_retry = (m_retry >= 255) ? 255 : m_retry + 1;
            m_fail_events++;
          end
        end else if (m_state == S_NARROW) begin
          if (ref_edge && !lock_in) ns = S_WIDE;
          else if (m_run_good >= LOCK_CNT) ns = S_LOCKED;
        end else begin
          if (m_run_bad >= UNLOCK_CNT) ns = S_WIDE;
        end
      end else if (m_state == S_NOREF) begin
        if (ref_edge) ns = S_PRESET;
      end else begin
        ns = S_IDLE;
      end
      m_lost = (m_state == S_LOCKED && (ns == S_WIDE || ns == S_NOREF)) ? 1 : 0;
      if (ns == S_IDLE) m_retry = 0;
      if (ns != m_state) begin
        m_dwell = 0; m_run_good = 0; m_run_bad = 0; m_edges = 0; m_quiet = 0;
      end
      m_state = ns;
    end
  endtask

  task automatic compare_all();
    int eh, eg;
    eh = (m_state == S_IDLE || m_state == S_PRESET || m_state == S_NOREF) ? 1 : 0;
    eg = (m_state == S_LOCKED) ? 0 : (m_state == S_NARROW) ? 1 : 2;
    check("state", 16'(state), 16'(m_state));
    check("pll_hold", 16'(pll_hold), 16'(eh));
    check("gain_sel", 16'(gain_sel), 16'(eg));
    check("lock_good", 16'(lock_good), 16'((m_state == S_LOCKED) ? 1 : 0));
    check("no_ref", 16'(no_ref), 16'((m_state == S_NOREF) ? 1 : 0));
    check("lost_lock", 16'(lost_lock), 16'(m_lost));
    check("retry_cnt", 16'(retry_cnt), 16'(m_retry));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_ticks(input int n);
    ref_edge = 1'b0;
    for (int i = 0; i < n; i++) begin
      lock_in = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic edge_tick(input bit good);
    ref_edge = 1'b1;
    lock_in = good;
    tick();
    ref_edge = 1'b0;
    lock_in = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_until(input int target, input int budget, input int good_pct, input string tag);
    int used;
    used = 0;
    while (m_state != target && used < budget) begin
      if ($urandom_range(0, 2) == 0) edge_tick($urandom_range(0, 99) < good_pct);
      else idle_ticks(1);
      used++;
    end
    check(tag, 16'(state), 16'(target));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 16'(state), 16'(S_IDLE));
    check({tag, "_hold"}, 16'(pll_hold), 16'(1));
    check({tag, "_gain"}, 16'(gain_sel), 16'(2));
    check({tag, "_lockgood"}, 16'(lock_good), 16'(0));
    check({tag, "_lost"}, 16'(lost_lock), 16'(0));
    check({tag, "_noref"}, 16'(no_ref), 16'(0));
    check({tag, "_retry"}, 16'(retry_cnt), 16'(0));
  endtask

  // Hard time limit so the run can never hang.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int start_fail;
    int used;

    // Reset with live, ignored inputs.
    rst = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ref_edge = 1'($urandom_range(0, 1));
      lock_in = 1'($urandom_range(0, 1));
      tick();
    end
    check_reset_values("reset");

    // Release: first cycle evaluates enable from IDLE, then PRESET for HOLD_CYC cycles.
    rst = 1'b0;
    ref_edge = 1'b0;
    tick();
    check("release_preset", 16'(state), 16'(S_PRESET));
    for (int i = 0; i < HOLD_CYC - 1; i++) begin
      ref_edge = 1'($urandom_range(0, 1));
      lock_in = 1'b0;
      tick();
    end
    check("preset_last_cycle", 16'(state), 16'(S_PRESET));
    ref_edge = 1'b0;
    tick();
    check("preset_to_wide", 16'(state), 16'(S_WIDE));

    // Clean acquisition.
    for (int i = 0; i < LOCK_CNT - 1; i++) begin
      idle_ticks($urandom_range(0, 6));
      edge_tick(1'b1);
    end
    check("wide_before_last", 16'(state), 16'(S_WIDE));
    idle_ticks($urandom_range(0, 6));
    edge_tick(1'b1);
    check("to_narrow", 16'(state), 16'(S_NARROW));
    check("narrow_gain", 16'(gain_sel), 16'(1));
    for (int i = 0; i < LOCK_CNT - 1; i++) begin
      idle_ticks($urandom_range(0, 6));
      edge_tick(1'b1);
    end
    check("narrow_before_last", 16'(state), 16'(S_NARROW));
    edge_tick(1'b1);
    check("to_locked", 16'(state), 16'(S_LOCKED));
    check("locked_good", 16'(lock_good), 16'(1));
    check("locked_gain", 16'(gain_sel), 16'(0));

    // Lock loss: 3 bad, 1 good, then UNLOCK_CNT bad.
    for (int i = 0; i < 3; i++) begin
      idle_ticks($urandom_range(0, 4));
      edge_tick(1'b0);
    end
    check("three_bad_locked", 16'(state), 16'(S_LOCKED));
    edge_tick(1'b1);
    for (int i = 0; i < UNLOCK_CNT - 1; i++) begin
      idle_ticks($urandom_range(0, 4));
      edge_tick(1'b0);
    end
    check("bad_run_locked", 16'(state), 16'(S_LOCKED));
    edge_tick(1'b0);
    check("unlock_wide", 16'(state), 16'(S_WIDE));
    check("unlock_lost", 16'(lost_lock), 16'(1));
    idle_ticks(1);
    check("unlock_lost_clear", 16'(lost_lock), 16'(0));

    // Reference loss from LOCKED.
    drive_until(S_LOCKED, 2000, 100, "relock_a");
    edge_tick(1'b1);
    idle_ticks(EDGE_TO - 1);
    check("pre_timeout_locked", 16'(state), 16'(S_LOCKED));
    idle_ticks(1);
    check("timeout_noref", 16'(state), 16'(S_NOREF));
    check("noref_flag", 16'(no_ref), 16'(1));
    check("noref_hold", 16'(pll_hold), 16'(1));
    check("noref_lost", 16'(lost_lock), 16'(1));
    idle_ticks(5);
    check("noref_stays", 16'(state), 16'(S_NOREF));
    edge_tick(1'b1);
    check("noref_to_preset", 16'(state), 16'(S_PRESET));

    // Reference edge on the exact timeout cycle keeps the state.
    drive_until(S_LOCKED, 2000, 100, "relock_b");
    edge_tick(1'b1);
    idle_ticks(EDGE_TO - 1);
    edge_tick(1'b1);
    check("edge_at_timeout", 16'(state), 16'(S_LOCKED));
    idle_ticks(EDGE_TO - 1);
    check("timer_restarted", 16'(state), 16'(S_LOCKED));
    edge_tick(1'b1);

    // Enable drop in LOCKED and mid ACQ_NARROW.
    enable = 1'b0;
    tick();
    check("disable_locked", 16'(state), 16'(S_IDLE));
    check("disable_no_lost", 16'(lost_lock), 16'(0));
    enable = 1'b1;
    drive_until(S_NARROW, 2000, 100, "reach_narrow");
    edge_tick(1'b1);
    enable = 1'b0;
    tick();
    check("disable_narrow", 16'(state), 16'(S_IDLE));
    check("disable_hold", 16'(pll_hold), 16'(1));

    // Acquisition failure and retry saturation.
    enable = 1'b1;
    tick();
    idle_ticks(HOLD_CYC);
    check("fail_wide", 16'(state), 16'(S_WIDE));
    for (int i = 0; i < ACQ_EDGES - 1; i++) begin
      idle_ticks($urandom_range(0, 2));
      edge_tick(1'b0);
    end
    check("budget_not_spent", 16'(state), 16'(S_WIDE));
    edge_tick(1'b0);
    check("budget_preset", 16'(state), 16'(S_PRESET));
    check("retry_one", 16'(retry_cnt), 16'(1));
    start_fail = m_fail_events;
    used = 0;
    while ((m_fail_events - start_fail) < 299 && used < 40000) begin
      if (m_state == S_WIDE) edge_tick(1'b0);
      else idle_ticks(1);
      used++;
    end
    check("retry_saturated", 16'(retry_cnt), 16'(255));
    check("retry_state", 16'(state), 16'(S_PRESET));
    idle_ticks(HOLD_CYC);
    idle_ticks(EDGE_TO);
    check("wide_timeout_noref", 16'(state), 16'(S_NOREF));
    check("noref_retry_kept", 16'(retry_cnt), 16'(255));
    edge_tick(1'b1);
    check("noref_preset_retry", 16'(retry_cnt), 16'(255));

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 99) < 97);
      ref_edge = ($urandom_range(0, 2) == 0);
      lock_in = ($urandom_range(0, 99) < 85);
      tick();
    end

    // Reset while LOCKED, then release.
    rst = 1'b0;
    enable = 1'b1;
    ref_edge = 1'b0;
    drive_until(S_LOCKED, 3000, 100, "relock_c");
    rst = 1'b1;
    ref_edge = 1'b1;
    lock_in = 1'b1;
    tick();
    check_reset_values("rst_locked");
    rst = 1'b0;
    ref_edge = 1'b0;
    tick();
    check("post_reset_preset", 16'(state), 16'(S_PRESET));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
